lsu_bus_interface: RTL
======================

// Module: lsu_bus_interface
// PURPOSE
//  Multi-cycle load/store responder that turns the decoder's MemWrite/load_store request into a bus transaction.
//  Sits between the RV32I datapath (ALU address, rs2 data) and a handshaked data-memory bus.
//  Stalls the core until the bus answers, aligns and extends load data, and generates byte strobes for stores.
//  Flags misaligned accesses, invalid size codes and bus timeouts instead of issuing or completing them.
// PARAMETERS
//  TIMEOUT   16   max cycles in BUS waiting for bus_ready; 0 = wait forever
//  CNT_W     5    width of timeout counter; must satisfy 2**CNT_W > TIMEOUT
// PORTS
//  clk          in   1   clock; all state updates on rising edge
//  rst_n        in   1   synchronous active-low reset
//  start        in   1   memory instruction present this cycle; held until stall=0
//  mem_write    in   1   1 = store, 0 = load (MemWrite from decoder)
//  load_store   in   3   funct3 size code: 000 B, 001 H, 010 W, 100 BU, 101 HU (loads); 000/001/010 (stores)
//  addr         in   32  byte address from ALU
//  wdata        in   32  store data (rs2)
//  stall        out  1   hold PC and pipeline inputs
//  done         out  1   1-cycle pulse: access finished (ok or fault)
//  fault        out  1   1-cycle pulse with done: misaligned, bad code or timeout
//  rdata        out  32  aligned and extended load result; valid while done=1
//  bus_req      out  1   bus request; held until bus_ready sampled high
//  bus_we       out  1   bus write enable
//  bus_addr     out  32  word address {addr[31:2],2'b00}
//  bus_wstrb    out  4   byte-lane strobes (0000 for loads)
//  bus_wdata    out  32  lane-replicated store data
//  bus_rdata    in   32  read word; sampled on the cycle bus_ready=1
//  bus_ready    in   1   bus accepts/completes the request this cycle
// BEHAVIOUR
//  Reset (rst_n=0 at edge): state=IDLE, counter=0; every output reg 0. No memory of an in-flight access.
//  stall = (state==IDLE & start) | state==BUS | state==CHECK; stall is 0 in RESP and in IDLE without start.
//  FSM states: IDLE, CHECK, BUS, RESP.
//  IDLE:  start=1 -> latch mem_write, load_store, addr, wdata -> CHECK. start=0 -> stay.
//  CHECK: misaligned (H/HU/SH with addr[0]=1; W/SW with addr[1:0]!=0) or invalid code
//         (load 011/110/111; store code other than 000/001/010) -> RESP with fault=1, rdata=0, no bus_req.
//         Otherwise -> BUS.
//  BUS:   bus_req=1; bus_we/bus_addr/bus_wstrb/bus_wdata constant for the whole state.
//         bus_ready=1 -> capture extended rdata -> RESP. Counter increments each BUS cycle without bus_ready.
//         TIMEOUT>0 and counter==TIMEOUT-1 with bus_ready=0 -> drop bus_req -> RESP with fault=1, rdata=0.
//  RESP:  done=1 for exactly 1 cycle; stall=0; counter cleared -> IDLE. start is ignored in RESP,
//         so back-to-back accesses cost one IDLE cycle each. Minimum latency: start to done = 3 cycles
//         with bus_ready=1 on the first BUS cycle.
//  Strobes: SB 4'b0001<<addr[1:0]; SH 4'b0011<<addr[1:0]; SW 4'b1111; loads 4'b0000.
//  Store data: SB {4{wdata[7:0]}}, SH {2{wdata[15:0]}}, SW wdata.
//  Load data: lane = bus_rdata >> (8*addr[1:0]). LB/LH sign-extend lane[7:0]/[15:0];
//             LBU/LHU zero-extend; LW uses the full word. rdata=0 after a store.
//  rdata holds its value until the next RESP; only done qualifies it.
//  Reset mid-BUS: bus_req is 0 from the next edge; no done pulse is produced.
// TESTING
//  LW addr=0x100, bus_ready on 1st BUS cycle, rdata=0xDEADBEEF -> done in cycle 3, rdata=0xDEADBEEF, fault=0.
//  LB addr=0x103, bus_rdata=0x80000000 -> rdata=0xFFFFFF80; same access as LBU -> rdata=0x00000080.
//  SH addr=0x202, wdata=0x1234ABCD -> bus_wstrb=1100, bus_wdata=0xABCDABCD, bus_we=1, bus_addr=0x200.
//  LW addr=0x101 -> no bus_req, done=1, fault=1, rdata=0; LH/SH addr=0x105 -> same fault result.
//  TIMEOUT=16, bus_ready held 0 -> bus_req high exactly 16 cycles, then done=1 and fault=1.
//  rst_n=0 during BUS with 5 wait cycles -> bus_req=0 and stall=0 next cycle; no done pulse.

Source files
------------

// File: rtl/lsu_bus_interface_if.sv
// Handshaked data-memory bus between the load/store unit (master) and memory (slave).
// Request fields are held stable while bus_req is high; bus_rdata is qualified by bus_ready.
interface lsu_bus_interface_if;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ready;

  modport master (
    output bus_req, bus_we, bus_addr, bus_wstrb, bus_wdata,
    input  bus_rdata, bus_ready
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_wstrb, bus_wdata,
    output bus_rdata, bus_ready
  );
endinterface

// File: rtl/lsu_bus_interface.sv
// Multi-cycle load/store unit: checks the request, runs one bus transaction with timeout,
// then returns aligned/extended load data with a one-cycle done pulse.
module lsu_bus_interface #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 5
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic                        mem_write,
  input  logic [2:0]                  load_store,
  input  logic [31:0]                 addr,
  input  logic [31:0]                 wdata,
  output logic                        stall,
  output logic                        done,
  output logic                        fault,
  output logic [31:0]                 rdata,
  lsu_bus_interface_if.master         bus
);

  typedef enum logic [1:0] {StIdle, StCheck, StBus, StResp} state_e;

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               mw_q;
  logic [2:0]         ls_q;
  logic [31:0]        addr_q;
  logic [31:0]        wdata_q;

  logic               bad_access;
  logic               timed_out;
  logic [3:0]         strb;
  logic [31:0]        lane_wdata;
  logic [31:0]        lane;
  logic [31:0]        load_ext;

  always_comb begin
    stall = ((state_q == StIdle) && start) || (state_q == StBus) || (state_q == StCheck);
  end

  // Invalid size codes fault regardless of alignment; misalignment is judged on size only.
  always_comb begin
    bad_access = 1'b0;
    if (mw_q) begin
      bad_access = !(ls_q == 3'b000 || ls_q == 3'b001 || ls_q == 3'b010);
    end else begin
      bad_access = (ls_q == 3'b011 || ls_q == 3'b110 || ls_q == 3'b111);
    end
    if (ls_q[1:0] == 2'b01 && addr_q[0]) bad_access = 1'b1;
    if (ls_q[1:0] == 2'b10 && addr_q[1:0] != 2'b00) bad_access = 1'b1;
  end

  always_comb begin
    strb       = 4'b0000;
    lane_wdata = wdata_q;
    unique case (ls_q[1:0])
      2'b00: begin
        strb       = 4'b0001 << addr_q[1:0];
        lane_wdata = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        strb       = 4'b0011 << addr_q[1:0];
        lane_wdata = {2{wdata_q[15:0]}};
      end
      default: begin
        strb       = 4'b1111;
        lane_wdata = wdata_q;
      end
    endcase
    if (!mw_q) strb = 4'b0000;
  end

  always_comb begin
    lane = bus.bus_rdata >> {addr_q[1:0], 3'b000};
    unique case (ls_q)
      3'b000:  load_ext = {{24{lane[7]}}, lane[7:0]};
      3'b001:  load_ext = {{16{lane[15]}}, lane[15:0]};
      3'b010:  load_ext = lane;
      3'b100:  load_ext = {24'd0, lane[7:0]};
      3'b101:  load_ext = {16'd0, lane[15:0]};
      default: load_ext = 32'd0;
    endcase
  end

  always_comb begin
    timed_out = (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT - 1)) && !bus.bus_ready;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      mw_q          <= 1'b0;
      ls_q          <= 3'b000;
      addr_q        <= 32'd0;
      wdata_q       <= 32'd0;
      done          <= 1'b0;
      fault         <= 1'b0;
      rdata         <= 32'd0;
      bus.bus_req   <= 1'b0;
      bus.bus_we    <= 1'b0;
      bus.bus_addr  <= 32'd0;
      bus.bus_wstrb <= 4'b0000;
      bus.bus_wdata <= 32'd0;
    end else begin
      done  <= 1'b0;
      fault <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            mw_q    <= mem_write;
            ls_q    <= load_store;
            addr_q  <= addr;
            wdata_q <= wdata;
            state_q <= StCheck;
          end
        end
        StCheck: begin
          if (bad_access) begin
            done    <= 1'b1;
            fault   <= 1'b1;
            rdata   <= 32'd0;
            state_q <= StResp;
          end else begin
            bus.bus_req   <= 1'b1;
            bus.bus_we    <= mw_q;
            bus.bus_addr  <= {addr_q[31:2], 2'b00};
            bus.bus_wstrb <= strb;
            bus.bus_wdata <= lane_wdata;
            cnt_q         <= '0;
            state_q       <= StBus;
          end
        end
        StBus: begin
          if (bus.bus_ready) begin
            bus.bus_req <= 1'b0;
            done        <= 1'b1;
            rdata       <= mw_q ? 32'd0 : load_ext;
            state_q     <= StResp;
          end else if (timed_out) begin
            bus.bus_req <= 1'b0;
            done        <= 1'b1;
            fault       <= 1'b1;
            rdata       <= 32'd0;
            state_q     <= StResp;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StResp: begin
          cnt_q   <= '0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
